bridge_sequencer: RTL and testbench
===================================

# bridge_sequencer

Full-bridge gate sequencer for the coil driver. It generates the two complementary diagonal drive signals, with gate_a_o driving GATE1/GATE3 and gate_b_o driving GATE2/GATE4, in the 160 MHz SoC clock domain. It inserts programmable dead time and runs bursts of a programmable cycle count, optionally terminating each half-cycle on the zero-current comparator. It latches a shutdown on over-temperature. Configuration comes from SoC gpio/wishbone registers; the burst enable comes from the fiber interrupter.

## Interface
- HALF_W, 12: width of half_period_i
- DEAD_W, 8: width of dead_time_i
- CNT_W, 16: width of max_cycles_i and cycle_count_o
- MIN_ON, 16: minimum on-time in cycles before a ZCS edge may end a half-cycle
- clk_i  in  1  160 MHz system clock; single clock domain
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  burst request (level)
- half_period_i  in  HALF_W  half-cycle length H in clocks, including dead time
- dead_time_i  in  DEAD_W  dead time D in clocks; 0 is treated as 1
- max_cycles_i  in  CNT_W  full cycles per burst; 0 = unlimited while enable_i is high
- zcs_mode_i  in  1  1 = end drive on ZCS edge, 0 = fixed timing
- zcs_i  in  1  zero-current comparator, already synchronized upstream
- over_temp_i  in  1  over-temperature comparator, already synchronized, active high
- fault_clear_i  in  1  single-cycle fault acknowledge
- gate_a_o  out  1  GATE1/GATE3 drive, registered
- gate_b_o  out  1  GATE2/GATE4 drive, registered
- busy_o  out  1  burst in progress
- fault_o  out  1  latched over-temperature fault
- cycle_count_o  out  CNT_W  full cycles completed in current/last burst

## Operation
- States: IDLE, DEAD_A, DRIVE_A, DEAD_B, DRIVE_B, FAULT.
- Reset values: state=IDLE, all outputs 0, armed=1, zcs history=0.
- **IDLE**
  - Gates low.
  - Start condition: enable_i=1, armed=1, and H >= Deff+1, where Deff=max(D,1).
  - On start: latch H, Deff, max_cycles, zcs_mode into shadow registers; clear cycle_count_o; go to DEAD_A.
  - An invalid H is ignored and the block stays in IDLE.
  - Input changes during a burst take effect only at the next start.
- **DEAD_A / DEAD_B**
  - Both gates low for Deff cycles, then go to DRIVE_A / DRIVE_B.
- **DRIVE_A / DRIVE_B**
  - Only the matching gate is high.
  - Fixed mode: lasts H-Deff cycles.
  - ZCS mode: ends on the first zcs_i rising edge (sampled 1, previous sample 0) once on-time >= MIN_ON; otherwise ends at the H-Deff timeout.
- **End of DRIVE_B**
  - cycle_count_o increments, saturating at all-ones.
  - Go to IDLE if enable_i=0, or if max_cycles≠0 and the new count equals max_cycles; otherwise go to DEAD_A.
  - enable_i falling mid-cycle never truncates the cycle; the current A+B pair completes.
- **Fault path**
  - over_temp_i sampled 1 in any state moves to FAULT on that edge: gates forced 0 on the same edge, fault_o=1, armed=0.
  - FAULT → IDLE on fault_clear_i=1 with over_temp_i=0; fault_o clears on that edge. fault_clear_i while over_temp_i=1 is ignored.
  - armed returns to 1 once enable_i is sampled 0, so a held enable cannot restart a burst after a fault.
- **Outputs**
  - busy_o=1 in DEAD_A, DRIVE_A, DEAD_B and DRIVE_B.
- **Invariants**
  - gate_a_o & gate_b_o == 0 on every cycle.
  - Every gate transition is separated from the opposite gate's rise by >= Deff cycles of both-low.
- **Simultaneous events**
  - over_temp_i has priority over everything.
  - reset_i has priority over over_temp_i.
  - reset_i mid-burst drops gates on that edge and returns to IDLE with fault_o=0.

## Timing
- Let edge 0 be the edge that samples the start condition.
- Fixed mode, per cycle:
  - gate_a_o high on edges Deff .. H-1.
  - gate_b_o high on edges H+Deff .. 2H-1.
  - Next DEAD_A at edge 2H.
  - Period 2H clocks; on-time per gate H-Deff clocks.
- Burst of N cycles: busy_o high for edges 0 .. 2NH-1; cycle_count_o=N from edge 2NH.
- ZCS: the gate falls on the edge after the edge that samples the zcs_i rise (1-cycle latency). The following dead time starts on that same edge.
- Fault: the gate falls on the edge that samples over_temp_i high (0 cycles of added latency beyond sampling).
- Start latency from enable_i sampled high to first gate_a_o high: Deff cycles.

## Test plan
- Fixed burst (H=100, D=10, max=3, enable held): gate_a high 90 clocks, gate_b high 90 clocks, 10-clock gaps, period 200; busy falls at edge 600; cycle_count_o=3; gates never overlap.
- Enable drop mid-cycle (H=50, D=5, max=0; enable=0 at edge 70, inside DRIVE_B): the cycle completes, IDLE at edge 100, cycle_count_o=1.
- ZCS mode (H=200, D=8, MIN_ON=16; zcs pulse rising at on-time 40, plus an earlier pulse at on-time 5): the early pulse is ignored; the gate falls one clock after the on-time-40 sample. With no pulse, it times out at 192 clocks.
- Over-temp mid-DRIVE_A: gates 0 on the sampling edge, fault_o=1.
  - fault_clear_i while over_temp_i=1 → no change.
  - fault_clear_i after over_temp_i=0 → IDLE, fault_o=0.
  - Held enable does not restart; enable low then high starts a new burst.
- Config edge cases:
  - D=0, H=2: behaves as Deff=1, gates each high 1 clock, period 4.
  - H=10, D=10: no start, busy_o stays 0.
  - Counter saturation with CNT_W=4 and max=0: count holds at 15.
- Reset mid-DRIVE_B with over_temp_i=1 on the same edge: gates 0, state IDLE, fault_o=0, cycle_count_o=0.

Source files
------------

// File: rtl/bridge_sequencer_if.sv
// Gate sequencer configuration, status and gate-drive signals between the SoC
// register block (master) and the full-bridge sequencer (slave).
interface bridge_sequencer_if #(
  parameter int unsigned HALF_W = 12,
  parameter int unsigned DEAD_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              enable_i;
  logic [HALF_W-1:0] half_period_i;
  logic [DEAD_W-1:0] dead_time_i;
  logic [CNT_W-1:0]  max_cycles_i;
  logic              zcs_mode_i;
  logic              zcs_i;
  logic              over_temp_i;
  logic              fault_clear_i;
  logic              gate_a_o;
  logic              gate_b_o;
  logic              busy_o;
  logic              fault_o;
  logic [CNT_W-1:0]  cycle_count_o;

  modport master (
    output enable_i, half_period_i, dead_time_i, max_cycles_i, zcs_mode_i,
           zcs_i, over_temp_i, fault_clear_i,
    input  gate_a_o, gate_b_o, busy_o, fault_o, cycle_count_o
  );

  modport slave (
    input  enable_i, half_period_i, dead_time_i, max_cycles_i, zcs_mode_i,
           zcs_i, over_temp_i, fault_clear_i,
    output gate_a_o, gate_b_o, busy_o, fault_o, cycle_count_o
  );
endinterface

// File: rtl/bridge_sequencer.sv
// Full-bridge diagonal gate sequencer: dead-time insertion, burst cycle counting,
// optional zero-current-switching half-cycle termination and latched over-temp shutdown.
module bridge_sequencer #(
  parameter int unsigned HALF_W = 12,
  parameter int unsigned DEAD_W = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned MIN_ON = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bridge_sequencer_if.slave bus
);

  localparam int unsigned CW = ((HALF_W > DEAD_W) ? HALF_W : DEAD_W) + 1;

  typedef enum logic [2:0] {IDLE, DEAD_A, DRIVE_A, DEAD_B, DRIVE_B, FAULT} state_t;

  state_t            state;
  logic [HALF_W-1:0] cnt;
  logic [HALF_W-1:0] drive_last_s;
  logic [DEAD_W-1:0] dead_last_s;
  logic [CNT_W-1:0]  max_s;
  logic              zcs_s;
  logic              armed;
  logic              zcs_d1, zcs_d2;

  logic [DEAD_W-1:0] d_eff;
  logic [CW-1:0]     h_ext, d_ext;
  logic              start_ok, zcs_end, drive_done, dead_done, burst_end;
  logic [CNT_W-1:0]  count_next;

  always_comb begin
    d_eff      = (bus.dead_time_i == '0) ? DEAD_W'(1) : bus.dead_time_i;
    h_ext      = CW'(bus.half_period_i);
    d_ext      = CW'(d_eff);
    start_ok   = bus.enable_i && armed && (h_ext > d_ext);
    // cnt at the edge after the sampled rise equals the on-time at the sample
    zcs_end    = zcs_s && zcs_d1 && !zcs_d2 && (32'(cnt) >= MIN_ON);
    drive_done = (cnt == drive_last_s) || zcs_end;
    dead_done  = (CW'(cnt) == CW'(dead_last_s));
    count_next = (bus.cycle_count_o == '1) ? bus.cycle_count_o
                                           : bus.cycle_count_o + CNT_W'(1);
    burst_end  = !bus.enable_i || ((max_s != '0) && (count_next == max_s));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= IDLE;
      cnt               <= '0;
      drive_last_s      <= '0;
      dead_last_s       <= '0;
      max_s             <= '0;
      zcs_s             <= 1'b0;
      armed             <= 1'b1;
      zcs_d1            <= 1'b0;
      zcs_d2            <= 1'b0;
      bus.gate_a_o      <= 1'b0;
      bus.gate_b_o      <= 1'b0;
      bus.busy_o        <= 1'b0;
      bus.fault_o       <= 1'b0;
      bus.cycle_count_o <= '0;
    end else begin
      zcs_d1 <= bus.zcs_i;
      zcs_d2 <= zcs_d1;
      if (bus.over_temp_i) begin
        state        <= FAULT;
        bus.gate_a_o <= 1'b0;
        bus.gate_b_o <= 1'b0;
        bus.busy_o   <= 1'b0;
        bus.fault_o  <= 1'b1;
        armed        <= 1'b0;
      end else begin
        if (!bus.enable_i) armed <= 1'b1;
        case (state)
          IDLE: begin
            bus.gate_a_o <= 1'b0;
            bus.gate_b_o <= 1'b0;
            if (start_ok) begin
              drive_last_s      <= HALF_W'(h_ext - d_ext - CW'(1));
              dead_last_s       <= d_eff - DEAD_W'(1);
              max_s             <= bus.max_cycles_i;
              zcs_s             <= bus.zcs_mode_i;
              bus.cycle_count_o <= '0;
              bus.busy_o        <= 1'b1;
              cnt               <= '0;
              state             <= DEAD_A;
            end
          end
          DEAD_A, DEAD_B: begin
            if (dead_done) begin
              cnt <= '0;
              if (state == DEAD_A) begin
                bus.gate_a_o <= 1'b1;
                state        <= DRIVE_A;
              end else begin
                bus.gate_b_o <= 1'b1;
                state        <= DRIVE_B;
              end
            end else begin
              cnt <= cnt + HALF_W'(1);
            end
          end
          DRIVE_A: begin
            if (drive_done) begin
              bus.gate_a_o <= 1'b0;
              cnt          <= '0;
              state        <= DEAD_B;
            end else begin
              cnt <= cnt + HALF_W'(1);
            end
          end
          DRIVE_B: begin
            if (drive_done) begin
              bus.gate_b_o      <= 1'b0;
              bus.cycle_count_o <= count_next;
              cnt               <= '0;
              if (burst_end) begin
                bus.busy_o <= 1'b0;
                state      <= IDLE;
              end else begin
                state      <= DEAD_A;
              end
            end else begin
              cnt <= cnt + HALF_W'(1);
            end
          end
          FAULT: begin
            if (bus.fault_clear_i) begin
              bus.fault_o <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bridge_sequencer.sv
// Directed bench for bridge_sequencer: fixed bursts, enable drop, ZCS termination,
// invalid config, counter saturation, fault latch/clear and reset priority.
module tb_bridge_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bridge_sequencer_if #(.HALF_W(12), .DEAD_W(8), .CNT_W(4)) bus ();

  bridge_sequencer #(.HALF_W(12), .DEAD_W(8), .CNT_W(4), .MIN_ON(16)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ed       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ed++;
  endtask

  task automatic step_to(input int e);
    while (ed < e) step();
  endtask

  task automatic configure(input int h, input int d, input int mx, input logic zm);
    bus.half_period_i = 12'(h);
    bus.dead_time_i   = 8'(d);
    bus.max_cycles_i  = 4'(mx);
    bus.zcs_mode_i    = zm;
  endtask

  // Runs an n-cycle burst from edge 0 and compares each edge to the timing formula.
  task automatic run_burst(input string tag, input int h, input int d, input int n);
    int   ea, eb, ebz, ov, ona, onb, p;
    logic xa, xb, xbz;
    ea = 0; eb = 0; ebz = 0; ov = 0; ona = 0; onb = 0;
    bus.enable_i = 1'b1;
    ed = -1;
    for (int e = 0; e <= 2 * n * h; e++) begin
      step();
      p   = e % (2 * h);
      xbz = (e < 2 * n * h);
      xa  = xbz && (p >= d) && (p < h);
      xb  = xbz && (p >= h + d);
      if (bus.gate_a_o !== xa) ea++;
      if (bus.gate_b_o !== xb) eb++;
      if (bus.busy_o !== xbz) ebz++;
      if (bus.gate_a_o === 1'b1 && bus.gate_b_o === 1'b1) ov++;
      if (bus.gate_a_o === 1'b1) ona++;
      if (bus.gate_b_o === 1'b1) onb++;
    end
    check({tag, "_gate_a_errs"}, 32'(ea), 0);
    check({tag, "_gate_b_errs"}, 32'(eb), 0);
    check({tag, "_busy_errs"}, 32'(ebz), 0);
    check({tag, "_overlap"}, 32'(ov), 0);
    check({tag, "_a_on_total"}, 32'(ona), 32'(n * (h - d)));
    check({tag, "_b_on_total"}, 32'(onb), 32'(n * (h - d)));
    check({tag, "_count"}, 32'(bus.cycle_count_o), 32'(n));
    bus.enable_i = 1'b0;
    step();
    step();
    check({tag, "_stays_idle"}, 32'(bus.busy_o), 0);
  endtask

  initial begin
    int bsum;
    rst               = 1'b1;
    bus.enable_i      = 1'b0;
    bus.zcs_i         = 1'b0;
    bus.over_temp_i   = 1'b0;
    bus.fault_clear_i = 1'b0;
    configure(100, 10, 3, 1'b0);
    step(); step(); step();
    check("rst_gate_a", 32'(bus.gate_a_o), 0);
    check("rst_gate_b", 32'(bus.gate_b_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_fault", 32'(bus.fault_o), 0);
    check("rst_count", 32'(bus.cycle_count_o), 0);
    rst = 1'b0;
    step();

    // Fixed burst, H=100 D=10, three cycles
    configure(100, 10, 3, 1'b0);
    run_burst("fixed", 100, 10, 3);

    // D=0 behaves as one dead clock, H=2
    configure(2, 0, 3, 1'b0);
    run_burst("d0", 2, 1, 3);

    // Enable dropped inside DRIVE_B of the first cycle
    configure(50, 5, 0, 1'b0);
    bus.enable_i = 1'b1;
    ed = -1;
    step_to(69);
    check("endrop_b_at69", 32'(bus.gate_b_o), 1);
    bus.enable_i = 1'b0;
    step_to(99);
    check("endrop_busy_at99", 32'(bus.busy_o), 1);
    check("endrop_b_at99", 32'(bus.gate_b_o), 1);
    step_to(100);
    check("endrop_busy_at100", 32'(bus.busy_o), 0);
    check("endrop_b_at100", 32'(bus.gate_b_o), 0);
    check("endrop_count", 32'(bus.cycle_count_o), 1);
    step_to(102);
    check("endrop_no_restart", 32'(bus.busy_o), 0);

    // ZCS: early pulse at on-time 5 ignored, rise at on-time 40 ends A; B times out
    configure(200, 8, 1, 1'b1);
    bus.enable_i = 1'b1;
    ed = -1;
    step();
    bus.enable_i = 1'b0;
    step_to(12);
    bus.zcs_i = 1'b1;
    step_to(13);
    bus.zcs_i = 1'b0;
    step_to(14);
    check("zcs_early_ignored", 32'(bus.gate_a_o), 1);
    step_to(47);
    bus.zcs_i = 1'b1;
    step_to(48);
    check("zcs_a_at_sample", 32'(bus.gate_a_o), 1);
    step_to(49);
    check("zcs_a_fall", 32'(bus.gate_a_o), 0);
    check("zcs_busy_dead", 32'(bus.busy_o), 1);
    step_to(56);
    check("zcs_b_dead", 32'(bus.gate_b_o), 0);
    step_to(57);
    check("zcs_b_rise", 32'(bus.gate_b_o), 1);
    step_to(248);
    check("zcs_b_last", 32'(bus.gate_b_o), 1);
    step_to(249);
    check("zcs_b_timeout", 32'(bus.gate_b_o), 0);
    check("zcs_idle", 32'(bus.busy_o), 0);
    check("zcs_count", 32'(bus.cycle_count_o), 1);
    bus.zcs_i = 1'b0;
    step(); step();

    // H equal to D is not a valid start
    configure(10, 10, 0, 1'b0);
    bus.enable_i = 1'b1;
    bsum = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy_o !== 1'b0) bsum++;
    end
    check("invalid_busy", 32'(bsum), 0);
    bus.enable_i = 1'b0;
    step();

    // Counter saturation at 15 with unlimited cycles
    configure(2, 0, 0, 1'b0);
    bus.enable_i = 1'b1;
    ed = -1;
    step_to(40);
    check("sat_count10", 32'(bus.cycle_count_o), 10);
    step_to(60);
    check("sat_count15", 32'(bus.cycle_count_o), 15);
    step_to(99);
    check("sat_hold", 32'(bus.cycle_count_o), 15);
    check("sat_busy", 32'(bus.busy_o), 1);
    bus.enable_i = 1'b0;
    step_to(100);
    check("sat_stop", 32'(bus.busy_o), 0);
    step();

    // Over-temp mid DRIVE_A, clear handling, re-arm, then reset with over-temp
    configure(100, 10, 0, 1'b0);
    bus.enable_i = 1'b1;
    ed = -1;
    step_to(29);
    check("ot_a_before", 32'(bus.gate_a_o), 1);
    bus.over_temp_i = 1'b1;
    step_to(30);
    check("ot_gate_a", 32'(bus.gate_a_o), 0);
    check("ot_fault", 32'(bus.fault_o), 1);
    check("ot_busy", 32'(bus.busy_o), 0);
    step_to(32);
    bus.fault_clear_i = 1'b1;
    step_to(33);
    bus.fault_clear_i = 1'b0;
    check("ot_clear_ignored", 32'(bus.fault_o), 1);
    step_to(34);
    bus.over_temp_i = 1'b0;
    step_to(36);
    check("ot_still_latched", 32'(bus.fault_o), 1);
    bus.fault_clear_i = 1'b1;
    step_to(37);
    bus.fault_clear_i = 1'b0;
    check("ot_cleared", 32'(bus.fault_o), 0);
    bsum = 0;
    while (ed < 45) begin
      step();
      if (bus.busy_o !== 1'b0) bsum++;
    end
    check("ot_held_enable_no_start", 32'(bsum), 0);
    bus.enable_i = 1'b0;
    step_to(46);
    bus.enable_i = 1'b1;
    step_to(47);
    check("ot_restart_busy", 32'(bus.busy_o), 1);
    step_to(56);
    check("ot_restart_dead", 32'(bus.gate_a_o), 0);
    step_to(57);
    check("ot_restart_a", 32'(bus.gate_a_o), 1);
    step_to(399);
    check("rst_mid_b_before", 32'(bus.gate_b_o), 1);
    check("rst_mid_count_before", 32'(bus.cycle_count_o), 1);
    rst             = 1'b1;
    bus.over_temp_i = 1'b1;
    step_to(400);
    check("rst_mid_gate_a", 32'(bus.gate_a_o), 0);
    check("rst_mid_gate_b", 32'(bus.gate_b_o), 0);
    check("rst_mid_busy", 32'(bus.busy_o), 0);
    check("rst_mid_fault", 32'(bus.fault_o), 0);
    check("rst_mid_count", 32'(bus.cycle_count_o), 0);
    rst             = 1'b0;
    bus.over_temp_i = 1'b0;
    bus.enable_i    = 1'b0;
    step_to(402);
    check("rst_mid_idle_busy", 32'(bus.busy_o), 0);
    check("rst_mid_idle_fault", 32'(bus.fault_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
